// File: rtl/elevator_call_queue.sv
// Button conditioning, pending-call latches and collective sweep scheduler for a 4-floor car.
// A held button shows as a call DB_CYCLES+2 edges after it rises; sweep and target are registered.
module elevator_call_queue #(
    parameter int DB_CYCLES = 4,
    parameter int NFLOORS   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] car_btn,
    input  logic [3:0] hall_up,
    input  logic [3:0] hall_dn,
    input  logic [1:0] cur_floor,
    input  logic       door_open,
    output logic [3:0] car_req,
    output logic [3:0] up_req,
    output logic [3:0] dn_req,
    output logic       any_above,
    output logic       any_below,
    output logic       any_here,
    output logic [1:0] sweep,
    output logic [1:0] target_floor,
    output logic       target_valid
);

    localparam int          NB     = 3 * NFLOORS;
    localparam logic [3:0]  DB_MAX = 4'(DB_CYCLES);
    localparam logic [3:0]  DB_M1  = 4'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DN   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nxt;

    logic [NB-1:0] w_raw;
    logic [NB-1:0] r_sync1;
    logic [NB-1:0] r_sync2;
    logic [NB-1:0] r_evt;
    logic [3:0]    r_cnt [NB];

    logic [3:0] r_car;
    logic [3:0] r_up;
    logic [3:0] r_dn;
    logic [3:0] w_pend;
    logic [3:0] w_clr;
    logic       w_above;
    logic       w_below;
    logic       w_here;

    logic [1:0] w_up_cand;
    logic       w_up_found;
    logic [1:0] w_dn_cand;
    logic       w_dn_found;
    logic [1:0] r_tgt;
    logic       r_tgt_vld;

    // Unused hall buttons (up at top floor, down at bottom floor) are forced low here.
    assign w_raw = {hall_dn & 4'b1110, hall_up & 4'b0111, car_btn};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_evt   <= '0;
            for (int i = 0; i < NB; i++) begin
                r_cnt[i] <= 4'd0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < NB; i++) begin
                // Pulse lines up with the one cycle the counter first reaches DB_MAX.
                r_evt[i] <= r_sync2[i] && (r_cnt[i] == DB_M1);
                if (!r_sync2[i]) begin
                    r_cnt[i] <= 4'd0;
                end else if (r_cnt[i] != DB_MAX) begin
                    r_cnt[i] <= r_cnt[i] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        w_clr = 4'b0000;
        for (int k = 0; k < NFLOORS; k++) begin
            w_clr[k] = door_open && (cur_floor == 2'(k));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_car <= 4'b0000;
            r_up  <= 4'b0000;
            r_dn  <= 4'b0000;
        end else begin
            r_car <= (r_car | r_evt[3:0]) & ~w_clr;
            r_up  <= (r_up | r_evt[7:4]) & ~(w_clr & {4{r_state != S_DN}}) & 4'b0111;
            r_dn  <= (r_dn | r_evt[11:8]) & ~(w_clr & {4{r_state != S_UP}}) & 4'b1110;
        end
    end

    assign w_pend = r_car | r_up | r_dn;

    always_comb begin
        w_above    = 1'b0;
        w_below    = 1'b0;
        w_here     = 1'b0;
        w_up_cand  = 2'd0;
        w_up_found = 1'b0;
        w_dn_cand  = 2'd0;
        w_dn_found = 1'b0;
        for (int k = 0; k < NFLOORS; k++) begin
            if (w_pend[k]) begin
                if (k > int'(cur_floor)) begin
                    w_above = 1'b1;
                end
                if (k < int'(cur_floor)) begin
                    w_below = 1'b1;
                    w_dn_cand  = 2'(k);
                    w_dn_found = 1'b1;
                end
                if (k == int'(cur_floor)) begin
                    w_here = 1'b1;
                end
            end
        end
        // Scan downward so the lowest floor above the car is the one kept.
        for (int k = NFLOORS - 1; k >= 0; k--) begin
            if (w_pend[k] && (k > int'(cur_floor))) begin
                w_up_cand  = 2'(k);
                w_up_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_nxt = r_state;
        if (!(door_open && w_here)) begin
            case (r_state)
                S_IDLE: begin
                    if (w_above)      w_nxt = S_UP;
                    else if (w_below) w_nxt = S_DN;
                end
                S_UP: begin
                    if (w_above)      w_nxt = S_UP;
                    else if (w_below) w_nxt = S_DN;
                    else              w_nxt = S_IDLE;
                end
                S_DN: begin
                    if (w_below)      w_nxt = S_DN;
                    else if (w_above) w_nxt = S_UP;
                    else              w_nxt = S_IDLE;
                end
                default: w_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_tgt     <= 2'd0;
            r_tgt_vld <= 1'b0;
        end else begin
            r_state <= w_nxt;
            case (r_state)
                S_UP: begin
                    if (w_up_found) r_tgt <= w_up_cand;
                    r_tgt_vld <= w_up_found;
                end
                S_DN: begin
                    if (w_dn_found) r_tgt <= w_dn_cand;
                    r_tgt_vld <= w_dn_found;
                end
                default: begin
                    r_tgt     <= cur_floor;
                    r_tgt_vld <= w_here;
                end
            endcase
        end
    end

    assign car_req      = r_car;
    assign up_req       = r_up;
    assign dn_req       = r_dn;
    assign any_above    = w_above;
    assign any_below    = w_below;
    assign any_here     = w_here;
    assign sweep        = r_state;
    assign target_floor = r_tgt;
    assign target_valid = r_tgt_vld;

endmodule

// File: tb/tb_elevator_call_queue.sv
// Directed bench for elevator_call_queue with DB_CYCLES=4; expectations are hand-derived edge counts.
module tb_elevator_call_queue;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] car_btn;
    logic [3:0] hall_up;
    logic [3:0] hall_dn;
    logic [1:0] cur_floor;
    logic       door_open;
    logic [3:0] car_req;
    logic [3:0] up_req;
    logic [3:0] dn_req;
    logic       any_above;
    logic       any_below;
    logic       any_here;
    logic [1:0] sweep;
    logic [1:0] target_floor;
    logic       target_valid;

    int checks = 0;
    int errors = 0;

    elevator_call_queue #(.DB_CYCLES(4), .NFLOORS(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .car_btn      (car_btn),
        .hall_up      (hall_up),
        .hall_dn      (hall_dn),
        .cur_floor    (cur_floor),
        .door_open    (door_open),
        .car_req      (car_req),
        .up_req       (up_req),
        .dn_req       (dn_req),
        .any_above    (any_above),
        .any_below    (any_below),
        .any_here     (any_here),
        .sweep        (sweep),
        .target_floor (target_floor),
        .target_valid (target_valid)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        car_btn   = 4'b0000;
        hall_up   = 4'b0000;
        hall_dn   = 4'b0000;
        cur_floor = 2'd0;
        door_open = 1'b0;
        step(2);
        check("rst_car", {4'h0, car_req}, 8'h00);
        check("rst_sweep", {6'h0, sweep}, 8'h00);
        check("rst_tgt", {5'h0, target_valid, target_floor}, 8'h00);

        // Car call to floor 2 from floor 0: latched on the 7th edge after the press.
        reset   = 1'b0;
        car_btn = 4'b0100;
        step(6);
        check("lat_early", {4'h0, car_req}, 8'h00);
        step(1);
        check("lat_car", {4'h0, car_req}, 8'h04);
        check("lat_above", {7'h0, any_above}, 8'h01);
        check("lat_sweep_idle", {6'h0, sweep}, 8'h00);
        step(1);
        check("t1_sweep_up", {6'h0, sweep}, 8'h01);
        step(1);
        check("t1_target", {5'h0, target_valid, target_floor}, 8'h06);
        cur_floor = 2'd2;
        door_open = 1'b1;
        step(1);
        check("t1_served", {4'h0, car_req}, 8'h00);
        check("t1_hold_up", {6'h0, sweep}, 8'h01);
        check("t1_tgt_none", {5'h0, target_valid, target_floor}, 8'h02);
        step(1);
        check("t1_idle", {6'h0, sweep}, 8'h00);
        car_btn   = 4'b0000;
        door_open = 1'b0;

        // Short glitch on car_btn[1]: three raw samples high never makes a call.
        car_btn = 4'b0010;
        step(3);
        car_btn = 4'b0000;
        step(8);
        check("glitch_car", {4'h0, car_req}, 8'h00);
        check("glitch_sweep", {6'h0, sweep}, 8'h00);
        check("glitch_any", {5'h0, any_above, any_below, any_here}, 8'h00);

        // Up and down hall calls at floor 1; serving while sweeping up keeps the down call.
        cur_floor = 2'd0;
        hall_up   = 4'b0010;
        hall_dn   = 4'b0010;
        step(7);
        check("t3_up", {4'h0, up_req}, 8'h02);
        check("t3_dn", {4'h0, dn_req}, 8'h02);
        hall_up = 4'b0000;
        hall_dn = 4'b0000;
        step(1);
        check("t3_sweep_up", {6'h0, sweep}, 8'h01);
        step(1);
        check("t3_target", {5'h0, target_valid, target_floor}, 8'h05);
        cur_floor = 2'd1;
        door_open = 1'b1;
        step(1);
        check("t3_up_clr", {4'h0, up_req}, 8'h00);
        check("t3_dn_kept", {4'h0, dn_req}, 8'h02);
        check("t3_held", {6'h0, sweep}, 8'h01);
        step(1);
        check("t3_held2", {6'h0, sweep}, 8'h01);
        door_open = 1'b0;
        step(1);
        check("t3_idle", {6'h0, sweep}, 8'h00);
        step(1);
        check("t3_idle_tgt", {5'h0, target_valid, target_floor}, 8'h05);
        door_open = 1'b1;
        step(1);
        check("t3_dn_clr", {4'h0, dn_req}, 8'h00);

        // Reverse: at floor 2 sweeping up with only a floor-0 car call left.
        door_open = 1'b0;
        cur_floor = 2'd2;
        car_btn   = 4'b1001;
        step(7);
        check("t4_car", {4'h0, car_req}, 8'h09);
        car_btn = 4'b0000;
        step(1);
        check("t4_up_prio", {6'h0, sweep}, 8'h01);
        step(1);
        check("t4_tgt3", {5'h0, target_valid, target_floor}, 8'h07);
        cur_floor = 2'd3;
        door_open = 1'b1;
        step(1);
        check("t4_car3_clr", {4'h0, car_req}, 8'h01);
        check("t4_hold", {6'h0, sweep}, 8'h01);
        cur_floor = 2'd2;
        door_open = 1'b0;
        step(1);
        check("t4_down", {6'h0, sweep}, 8'h02);
        step(1);
        check("t4_tgt0", {5'h0, target_valid, target_floor}, 8'h04);
        cur_floor = 2'd0;
        door_open = 1'b1;
        step(1);
        check("t4_car0_clr", {4'h0, car_req}, 8'h00);
        check("t4_hold_dn", {6'h0, sweep}, 8'h02);
        step(1);
        check("t4_idle", {6'h0, sweep}, 8'h00);
        check("t4_tvld", {7'h0, target_valid}, 8'h00);
        door_open = 1'b0;

        // Hall-up at floor 0 while the door is open there: clear wins every cycle.
        door_open = 1'b1;
        hall_up   = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("t5_up0", {4'h0, up_req}, 8'h00);
        end
        door_open = 1'b0;
        step(2);
        check("t5_no_refire", {4'h0, up_req}, 8'h00);
        hall_up = 4'b0000;

        // Async reset with a call pending and a second button mid-debounce.
        car_btn = 4'b1000;
        step(7);
        check("t6_car", {4'h0, car_req}, 8'h08);
        step(2);
        check("t6_up", {6'h0, sweep}, 8'h01);
        car_btn = 4'b1010;
        step(3);
        reset = 1'b1;
        #1;
        check("t6_rst_car", {4'h0, car_req}, 8'h00);
        check("t6_rst_sweep", {6'h0, sweep}, 8'h00);
        check("t6_rst_any", {5'h0, any_above, any_below, any_here}, 8'h00);
        check("t6_rst_tgt", {5'h0, target_valid, target_floor}, 8'h00);
        step(2);
        check("t6_rst_hold", {4'h0, car_req}, 8'h00);
        reset   = 1'b0;
        car_btn = 4'b1000;
        step(6);
        check("t6_redb_early", {4'h0, car_req}, 8'h00);
        step(1);
        check("t6_redb", {4'h0, car_req}, 8'h08);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/elevator_call_queue.md
Name: elevator_call_queue

Overview:
- Upstream stage of the elevator controller. Conditions raw car and hall buttons through a 2-flop synchroniser and a per-button debounce counter.
- Latches every debounced press as a pending call and holds it until the car services that floor with the door open.
- Runs a 3-state direction scheduler (collective up/down sweep) and presents the pending-call vectors, above/below/here summaries and the next target floor to the controller.

Parameters:
- DB_CYCLES, 4, consecutive synchronised-high cycles required to accept a press (1..15).
- NFLOORS, 4, floor count; indices 0..3 map to F1..F4. Fixed at 4 in this revision.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- car_btn  in  4  raw in-car floor buttons; bit k = floor k
- hall_up  in  4  raw hall up buttons; bits 0..2 used, bit 3 ignored
- hall_dn  in  4  raw hall down buttons; bits 1..3 used, bit 0 ignored
- cur_floor  in  2  current floor index, binary 0..3
- door_open  in  1  door fully open at cur_floor (service strobe, level)
- car_req  out  4  pending car calls
- up_req  out  4  pending hall-up calls; bit 3 always 0
- dn_req  out  4  pending hall-down calls; bit 0 always 0
- any_above  out  1  some pending call at a floor > cur_floor
- any_below  out  1  some pending call at a floor < cur_floor
- any_here  out  1  some pending call at cur_floor
- sweep  out  2  scheduler state: 0 IDLE, 1 UP, 2 DOWN
- target_floor  out  2  nearest pending floor in the sweep direction
- target_valid  out  1  target_floor meaningful

Behaviour:
- Reset (async, any time, including mid-debounce): all sync flops, debounce counters and call latches cleared. All outputs 0 and sweep=IDLE on assertion; no output glitches high during reset.
- Debounce, per used button:
  - Raw input passes 2 sync flops, giving s.
  - A 4-bit counter increments while s=1 and saturates at DB_CYCLES; s=0 clears it to 0.
  - A press event fires only on the cycle the counter first equals DB_CYCLES. Holding the button does not re-fire.
  - Any low sample before DB_CYCLES aborts the press.
- Latency: with the raw input high from edge E, the call bit is visible after edge E+DB_CYCLES+2.
- Call set/clear, per floor k:
  - A press event sets the bit. Already-set bits stay set.
  - Clear condition: door_open=1 and cur_floor=k. Then car_req[k] clears; up_req[k] clears when sweep≠DOWN; dn_req[k] clears when sweep≠UP.
  - A press event and a clear condition on the same bit in the same cycle: clear wins (the passenger is being served).
  - Set and clear on different floors are independent.
- Pending(k) = car_req[k] | up_req[k] | dn_req[k].
- any_above, any_below and any_here are combinational from the call registers and cur_floor.
- Scheduler, registered, evaluated every edge:
  - IDLE: any_above → UP; else any_below → DOWN; else stay. Above takes priority when both are set.
  - UP: stay while any_above; else any_below → DOWN; else → IDLE.
  - DOWN: stay while any_below; else any_above → UP; else → IDLE.
  - While door_open=1 and any_here=1, the state is held (calls must be cleared first).
- Target, registered, 1 cycle after its inputs:
  - UP: lowest pending floor > cur_floor.
  - DOWN: highest pending floor < cur_floor.
  - IDLE: target_floor=cur_floor, target_valid=any_here.
  - No candidate: target_valid=0 and target_floor holds its previous value.
- Boundaries:
  - At floor 3, up_req[3] is never set; at floor 0, dn_req[0] is never set.
  - A cur_floor change takes effect on the next evaluation; no call is lost in transit.

Test Plan:
- DB_CYCLES=4; car_btn[2] high from edge 10, cur_floor=0 → car_req=4'b0100 after edge 16, any_above=1; sweep=UP and target_floor=2, target_valid=1 by edge 18.
- car_btn[1] pulsed high for 3 cycles (< DB_CYCLES) → car_req stays 0, no sweep change.
- Pending up_req[1] and dn_req[1], sweep=UP; set cur_floor=1 and door_open=1 → up_req[1] clears next edge, dn_req[1] stays 1.
- cur_floor=2, sweep=UP, only car_req[0] pending → sweep=DOWN next edge, target_floor=0; release all calls → sweep returns to IDLE, target_valid=0.
- Press hall_up[0] at cur_floor=0 with door_open=1, held → up_req[0] never observed 1 while the door is open.
- Assert reset mid-debounce and with calls pending → all outputs 0 immediately; after release, the same held button needs the full DB_CYCLES+2 again.
